// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the two-client SPI burst arbiter.
package spi_arb_pkg;
    localparam int LEN_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/spi_arb_rr.sv
// Two-way picker: on a tie the client not granted last (i_last) wins.
module spi_arb_rr
    import spi_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_grant,
    output logic       o_valid
);
    always_comb begin
        o_valid = |i_req;
        if (i_req == 2'b11) o_grant = ~i_last;
        else                o_grant = i_req[1];
    end
endmodule

// File: rtl/spi_arb.sv
// Two-client burst arbiter in front of a single SPI byte engine.
// Define SPI_ARB_RR_EN for round-robin arbitration; default is fixed priority (client 0 wins).
//
// state    | meaning
// IDLE     | no owner; arbitrate pending requests
// ISSUE    | offer granted client's byte to the engine while it is ready
// WAIT     | byte in flight; wait for spi_done
// DONE     | burst finished; pulse done, release grant
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c0_req,
    input  logic [LEN_W-1:0] c0_len,
    input  logic [7:0]       c0_tx_data,
    output logic             c0_gnt,
    output logic             c0_tx_ack,
    output logic [7:0]       c0_rx_data,
    output logic             c0_rx_valid,
    output logic             c0_done,
    input  logic             c1_req,
    input  logic [LEN_W-1:0] c1_len,
    input  logic [7:0]       c1_tx_data,
    output logic             c1_gnt,
    output logic             c1_tx_ack,
    output logic [7:0]       c1_rx_data,
    output logic             c1_rx_valid,
    output logic             c1_done,
    output logic             spi_req,
    output logic [7:0]       spi_data_out,
    input  logic             spi_rdy,
    input  logic [7:0]       spi_data_in,
    input  logic             spi_done,
    output logic             busy
);
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t           r_state;
    logic             r_sel;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [1:0]       r_gnt;
    logic [1:0]       r_rx_valid;
    logic [1:0]       r_done;
    logic [7:0]       r_rx_data0;
    logic [7:0]       r_rx_data1;
    logic             w_grant;
    logic             w_valid;
    logic             w_last;
    logic             w_issue;

`ifdef SPI_ARB_RR_EN
    logic r_last;
    assign w_last = r_last;
`else
    // Pretending client 1 was always granted last makes the picker fixed-priority.
    assign w_last = 1'b1;
`endif

    spi_arb_rr u_rr (
        .i_req   ({c1_req, c0_req}),
        .i_last  (w_last),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sel      <= 1'b0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_gnt      <= 2'b00;
            r_rx_valid <= 2'b00;
            r_done     <= 2'b00;
            r_rx_data0 <= 8'h00;
            r_rx_data1 <= 8'h00;
`ifdef SPI_ARB_RR_EN
            r_last     <= 1'b1;
`endif
        end else begin
            r_rx_valid <= 2'b00;
            r_done     <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_sel   <= w_grant;
                        r_len   <= w_grant ? c1_len : c0_len;
                        r_cnt   <= '0;
                        r_gnt   <= w_grant ? 2'b10 : 2'b01;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (spi_rdy) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (spi_done) begin
                        if (r_sel) r_rx_data1 <= spi_data_in;
                        else       r_rx_data0 <= spi_data_in;
                        r_rx_valid <= r_sel ? 2'b10 : 2'b01;
                        // Wrapping compare: len 0 runs the full 2**LEN_W bytes.
                        if (r_cnt == r_len - ONE) begin
                            r_gnt   <= 2'b00;
                            r_done  <= r_sel ? 2'b10 : 2'b01;
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt   <= r_cnt + ONE;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
`ifdef SPI_ARB_RR_EN
                    r_last  <= r_sel;
`endif
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_issue      = (r_state == ST_ISSUE);
    assign spi_req      = w_issue & spi_rdy;
    assign spi_data_out = w_issue ? (r_sel ? c1_tx_data : c0_tx_data) : 8'h00;
    assign c0_tx_ack    = spi_req & ~r_sel;
    assign c1_tx_ack    = spi_req & r_sel;
    assign c0_gnt       = r_gnt[0];
    assign c1_gnt       = r_gnt[1];
    assign c0_rx_valid  = r_rx_valid[0];
    assign c1_rx_valid  = r_rx_valid[1];
    assign c0_done      = r_done[0];
    assign c1_done      = r_done[1];
    assign c0_rx_data   = r_rx_data0;
    assign c1_rx_data   = r_rx_data1;
    assign busy         = (r_state != ST_IDLE);
endmodule

// File: tb/tb_spi_arb.sv
// Directed bench for spi_arb: vector table of bursts plus corner-case sequences.
module tb_spi_arb;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       c0_req = 1'b0, c1_req = 1'b0;
    logic [3:0] c0_len = 4'd0, c1_len = 4'd0;
    logic [7:0] c0_tx_data = 8'h00, c1_tx_data = 8'h00;
    logic       c0_gnt, c1_gnt, c0_tx_ack, c1_tx_ack, c0_rx_valid, c1_rx_valid, c0_done, c1_done;
    logic [7:0] c0_rx_data, c1_rx_data;
    logic       spi_req, busy;
    logic [7:0] spi_data_out;
    logic       spi_rdy = 1'b1;
    logic [7:0] spi_data_in = 8'h00;
    logic       spi_done = 1'b0;

    spi_arb #(.LEN_W(4)) dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_len(c0_len), .c0_tx_data(c0_tx_data), .c0_gnt(c0_gnt),
        .c0_tx_ack(c0_tx_ack), .c0_rx_data(c0_rx_data), .c0_rx_valid(c0_rx_valid), .c0_done(c0_done),
        .c1_req(c1_req), .c1_len(c1_len), .c1_tx_data(c1_tx_data), .c1_gnt(c1_gnt),
        .c1_tx_ack(c1_tx_ack), .c1_rx_data(c1_rx_data), .c1_rx_valid(c1_rx_valid), .c1_done(c1_done),
        .spi_req(spi_req), .spi_data_out(spi_data_out), .spi_rdy(spi_rdy),
        .spi_data_in(spi_data_in), .spi_done(spi_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    logic [7:0] tx0 [32], tx1 [32], rxlog0 [32], rxlog1 [32];
    int ord [8];
    int nord, ack0, ack1, rxv0, rxv1, done0, done1, ng0, ng1, tidx0, tidx1;
    int bursts0 = 0, bursts1 = 0, eng_t = 0;
    logic [3:0] len0 = 4'd0, len1 = 4'd0;
    logic drop0 = 1'b0, rdy_en = 1'b1, spur = 1'b0, adv0 = 1'b0, adv1 = 1'b0, pg0 = 1'b0, pg1 = 1'b0;
    logic [7:0] eng_byte = 8'h00;

    typedef struct {
        logic [3:0] len0; int b0; logic drop0; logic [3:0] len1; int b1; int e_ack0; int e_ack1;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_counts();
        ack0 = 0; ack1 = 0; rxv0 = 0; rxv1 = 0; done0 = 0; done1 = 0;
        ng0 = 0; ng1 = 0; nord = 0; tidx0 = 0; tidx1 = 0; adv0 = 0; adv1 = 0;
        pg0 = 0; pg1 = 0;
    endtask

    task automatic start(input logic [3:0] l0, input int b0v, input logic d0,
                         input logic [3:0] l1, input int b1v);
        rst = 1'b1;
        len0 = l0; bursts0 = b0v; drop0 = d0; len1 = l1; bursts1 = b1v;
        @(negedge clk); @(negedge clk); #2;
        clear_counts();
        c0_tx_data = tx0[0]; c1_tx_data = tx1[0];
        rst = 1'b0;
    endtask

    task automatic run_idle(input string nm);
        int t = 0;
        while (t < 2000 && (bursts0 > 0 || bursts1 > 0 || busy)) begin
            @(negedge clk); #3; t++;
        end
        repeat (3) @(negedge clk);
        #3;
        chk({nm, "_timeout"}, int'(t >= 2000), 0);
    endtask

    task automatic wait_gnt0(input string nm);
        int t = 0;
        while (t < 200 && !c0_gnt) begin @(negedge clk); #3; t++; end
        chk({nm, "_gnt_timeout"}, int'(t >= 200), 0);
    endtask

    function automatic int rx_mism0();
        int m = 0;
        for (int k = 0; k < rxv0 && k < 32; k++) if (rxlog0[k] != tx0[k]) m++;
        return m;
    endfunction

    function automatic int rx_mism1();
        int m = 0;
        for (int k = 0; k < rxv1 && k < 32; k++) if (rxlog1[k] != tx1[k]) m++;
        return m;
    endfunction

    function automatic int outs();
        return int'({c0_gnt, c1_gnt, c0_tx_ack, c1_tx_ack, c0_rx_valid, c1_rx_valid,
                     c0_done, c1_done, spi_req, busy});
    endfunction

    // Client and loopback engine model; registered DUT outputs are sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (adv0) begin tidx0++; adv0 = 1'b0; end
            if (adv1) begin tidx1++; adv1 = 1'b0; end
            c0_tx_data = tx0[tidx0 % 32];
            c1_tx_data = tx1[tidx1 % 32];
            spi_done = 1'b0;
            if (eng_t > 0) begin
                eng_t--;
                if (eng_t == 0) begin spi_done = 1'b1; spi_data_in = eng_byte; end
            end else if (spur) begin
                spi_done = 1'b1; spi_data_in = 8'hEE; spur = 1'b0;
            end
            spi_rdy = rdy_en && (eng_t == 0);
            if (c0_rx_valid) begin if (rxv0 < 32) rxlog0[rxv0] = c0_rx_data; rxv0++; end
            if (c1_rx_valid) begin if (rxv1 < 32) rxlog1[rxv1] = c1_rx_data; rxv1++; end
            if (c0_done) begin done0++; if (bursts0 > 0) bursts0--; end
            if (c1_done) begin done1++; if (bursts1 > 0) bursts1--; end
            if (c0_gnt && !pg0) begin ng0++; if (nord < 8) ord[nord] = 0; nord++; end
            if (c1_gnt && !pg1) begin ng1++; if (nord < 8) ord[nord] = 1; nord++; end
            pg0 = c0_gnt; pg1 = c1_gnt;
            c0_req = (bursts0 > 0) && !(drop0 && c0_gnt);
            c1_req = (bursts1 > 0);
            c0_len = len0; c1_len = len1;
            #1;
            if (spi_req) begin
                eng_byte = spi_data_out; eng_t = 3;
                if (c0_tx_ack) begin ack0++; adv0 = 1'b1; end
                if (c1_tx_ack) begin ack1++; adv1 = 1'b1; end
            end
        end
    end

    initial begin
        int viol;
        int exp_ord [4];
        for (int k = 0; k < 32; k++) begin
            tx0[k] = 8'(8'h11 * (k + 1));
            tx1[k] = 8'(k);
        end
        //           len0  b0 drop len1 b1 ack0 ack1
        vecs[0] = '{4'd3,  1, 1'b0, 4'd0, 0,  3,  0};
        vecs[1] = '{4'd0,  0, 1'b0, 4'd0, 1,  0, 16};
        vecs[2] = '{4'd1,  1, 1'b0, 4'd2, 1,  1,  2};
        vecs[3] = '{4'd2,  2, 1'b0, 4'd1, 2,  4,  2};
        vecs[4] = '{4'd3,  1, 1'b1, 4'd0, 0,  3,  0};
        vecs[5] = '{4'd15, 1, 1'b0, 4'd1, 1, 15,  1};
        clear_counts();

        // Reset state
        @(posedge clk); #2;
        chk("rst_outs", outs(), 0);
        chk("rst_spi_data_out", int'(spi_data_out), 0);
        chk("rst_rx0", int'(c0_rx_data), 0);
        chk("rst_rx1", int'(c1_rx_data), 0);

        for (int v = 0; v < 6; v++) begin
            start(vecs[v].len0, vecs[v].b0, vecs[v].drop0, vecs[v].len1, vecs[v].b1);
            run_idle($sformatf("v%0d", v));
            chk($sformatf("v%0d_ack0", v), ack0, vecs[v].e_ack0);
            chk($sformatf("v%0d_ack1", v), ack1, vecs[v].e_ack1);
            chk($sformatf("v%0d_rxv0", v), rxv0, vecs[v].e_ack0);
            chk($sformatf("v%0d_rxv1", v), rxv1, vecs[v].e_ack1);
            chk($sformatf("v%0d_done0", v), done0, vecs[v].b0);
            chk($sformatf("v%0d_done1", v), done1, vecs[v].b1);
            chk($sformatf("v%0d_gnts0", v), ng0, vecs[v].b0);
            chk($sformatf("v%0d_gnts1", v), ng1, vecs[v].b1);
            chk($sformatf("v%0d_rxdata0", v), rx_mism0(), 0);
            chk($sformatf("v%0d_rxdata1", v), rx_mism1(), 0);
        end

        // Grant order with both clients requesting from reset
`ifdef SPI_ARB_RR_EN
        exp_ord = '{0, 1, 0, 1};
`else
        exp_ord = '{0, 0, 1, 1};
`endif
        start(4'd1, 2, 1'b0, 4'd1, 2);
        run_idle("order");
        chk("order_n", nord, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("order_%0d", i), ord[i], exp_ord[i]);

        // Engine not ready: request held off
        rdy_en = 1'b0;
        start(4'd1, 1, 1'b0, 4'd0, 0);
        wait_gnt0("stall");
        viol = 0;
        repeat (20) begin
            @(negedge clk); #2;
            if (spi_req || c0_tx_ack) viol++;
        end
        chk("stall_no_req", viol, 0);
        chk("stall_ack0", ack0, 0);
        rdy_en = 1'b1;
        @(negedge clk); #2;
        chk("stall_req_on_rdy", int'(spi_req), 1);
        chk("stall_ack_on_rdy", int'(c0_tx_ack), 1);
        chk("stall_data_out", int'(spi_data_out), 8'h11);
        run_idle("stall");
        chk("stall_done0", done0, 1);

        // Spurious spi_done in IDLE and ISSUE
        start(4'd0, 0, 1'b0, 4'd0, 0);
        spur = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("spur_idle_rxv", rxv0 + rxv1, 0);
        chk("spur_idle_busy", int'(busy), 0);
        rdy_en = 1'b0; len0 = 4'd2; bursts0 = 1;
        wait_gnt0("spur");
        spur = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("spur_issue_rxv", rxv0, 0);
        chk("spur_issue_ack", ack0, 0);
        rdy_en = 1'b1;
        run_idle("spur");
        chk("spur_ack0", ack0, 2);
        chk("spur_rxv0", rxv0, 2);
        chk("spur_done0", done0, 1);
        chk("spur_rxdata0", rx_mism0(), 0);

        // Reset in WAIT of byte 2 of 4
        start(4'd4, 1, 1'b0, 4'd0, 0);
        begin
            int t = 0;
            while (t < 200 && ack0 < 2) begin @(negedge clk); #2; t++; end
            chk("midrst_wait_timeout", int'(t >= 200), 0);
        end
        @(posedge clk); #3;
        chk("midrst_busy", int'(busy), 1);
        chk("midrst_rx0_before", int'(c0_rx_data), 8'h11);
        rst = 1'b1;
        #1;
        chk("midrst_outs", outs(), 0);
        chk("midrst_spi_data_out", int'(spi_data_out), 0);
        chk("midrst_rx0", int'(c0_rx_data), 0);
        @(negedge clk); @(negedge clk); #2;
        chk("midrst_no_done", done0, 0);
        clear_counts();
        rst = 1'b0;
        run_idle("midrst");
        chk("midrst_ack0", ack0, 4);
        chk("midrst_rxv0", rxv0, 4);
        chk("midrst_done0", done0, 1);
        chk("midrst_rxdata0", rx_mism0(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/spi_arb.md
SPI_ARB -- requirements
Module: spi_arb

Interface
REQ-001 SHALL have parameter: LEN_W, 4, width of burst-length field; length 0 encodes 2**LEN_W bytes.
REQ-002 SHALL have one clock, clk; reset is rst, asynchronous and active-high.
REQ-003 SHALL have ports (N = 0,1, one set per client):
- clk  in  1  clock
- rst  in  1  async active-high reset
- cN_req  in  1  level request; held until cN_done
- cN_len  in  LEN_W  burst length in bytes, sampled at grant
- cN_tx_data  in  8  current byte to send, valid while cN_gnt
- cN_gnt  out  1  client N owns the engine
- cN_tx_ack  out  1  one-cycle pulse; cN_tx_data consumed, present next byte
- cN_rx_data  out  8  received byte
- cN_rx_valid  out  1  one-cycle pulse; cN_rx_data valid
- cN_done  out  1  one-cycle pulse; burst complete
- spi_req  out  1  byte request to SPI byte engine
- spi_data_out  out  8  byte to engine
- spi_rdy  in  1  engine idle/accepting
- spi_data_in  in  8  byte from engine, valid with spi_done
- spi_done  in  1  one-cycle pulse; byte complete
- busy  out  1  state != IDLE

Function
REQ-004 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-005 IDLE: if any cN_req, grant one client per REQ-012, latch cN_len, clear byte count, -> ISSUE; else stay.
REQ-006 ISSUE: spi_req SHALL equal spi_rdy combinationally; spi_data_out = granted cN_tx_data; on spi_req&&spi_rdy pulse cN_tx_ack same cycle, -> WAIT.
REQ-007 WAIT: on spi_done, register spi_data_in to cN_rx_data and pulse cN_rx_valid the following cycle; if count == len-1 (mod 2**LEN_W) -> DONE, else count+1 -> ISSUE.
REQ-008 DONE: pulse cN_done one cycle, update round-robin pointer, deassert cN_gnt, -> IDLE; no arbitration in DONE (minimum one IDLE cycle between bursts).
REQ-009 cN_gnt SHALL be high in ISSUE and WAIT for the granted client only; both low in IDLE and DONE.
REQ-010 Outside ISSUE, spi_req = 0 and spi_data_out = 0.
REQ-011 spi_done outside WAIT SHALL be ignored; requester dropping cN_req mid-burst SHALL NOT abort the burst.
REQ-012 Simultaneous requests: the client not granted last wins; the other waits in order.
REQ-013 Byte counter SHALL be LEN_W bits, wrapping, so cN_len = 0 yields exactly 2**LEN_W bytes.

Reset
REQ-014 On rst: state IDLE, all outputs 0, count 0, cN_rx_data 0, round-robin pointer = client 1 (client 0 wins first tie).
REQ-015 rst mid-burst SHALL abort immediately with no cN_done; the SPI engine is not signalled.

Configuration
REQ-016 With SPI_ARB_RR_EN defined, arbitration SHALL be round-robin per REQ-012.
REQ-017 Without SPI_ARB_RR_EN, arbitration SHALL be fixed priority, client 0 always wins; pointer logic absent.

Structure
REQ-018 Shared package spi_arb_pkg SHALL hold the state enum type and default LEN_W constant.
REQ-019 Two-way picker SHALL be a sub-module spi_arb_rr (inputs req[1:0], last; output grant index, valid).

Verification
REQ-020 c0_req, c0_len=3, tx bytes 0x11,0x22,0x33, engine loops MOSI->MISO -> three c0_tx_ack, c0_rx_data 0x11,0x22,0x33, one c0_done, c1 signals silent.
REQ-021 c0_req and c1_req both high from reset, len=1 each -> c0 burst first, then c1; with RR repeated requests alternate 0,1,0,1; without macro c0 starves c1.
REQ-022 c1_len=0, tx 0x00..0x0F -> exactly 16 cN_tx_ack and 16 cN_rx_valid, then c1_done.
REQ-023 spi_rdy held low 20 cycles during ISSUE -> spi_req stays low, no tx_ack; spi_rdy high -> byte issued same cycle.
REQ-024 Spurious spi_done pulse in IDLE and ISSUE -> no rx_valid, count unchanged.
REQ-025 rst asserted in WAIT of byte 2 of 4 -> all outputs 0 asynchronously, no cN_done; after release, pending c0_req regranted with fresh count.
